// File: rtl/audio_codec_emu.sv
// Codec-side emulator for a serial audio link: generates BCLK/LRCK, shifts ADC samples out
// LSB first and assembles DAC samples received on AUD_DACDAT into complete stereo frames.
module audio_codec_emu #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned SLOT_BITS = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic [15:0] i_adc_left,
  input  logic [15:0] i_adc_right,
  output logic        o_adc_load,
  output logic        o_aud_bclk,
  output logic        o_aud_adclrck,
  output logic        o_aud_daclrck,
  output logic        o_aud_adcdat,
  input  logic        i_aud_dacdat,
  output logic [15:0] o_dac_left,
  output logic [15:0] o_dac_right,
  output logic        o_dac_valid
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned PW   = $clog2(SLOT_BITS);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [PW-1:0]   PLast   = PW'(SLOT_BITS - 1);

  logic [DivW-1:0] r_div;
  logic [PW-1:0]   r_p;
  logic            r_bclk, r_lrck, r_left, r_got_left, r_adcdat, r_adc_load, r_dac_valid;
  logic [15:0]     r_sh_l, r_sh_r, r_asm_l, r_asm_r, r_dac_left, r_dac_right;

  logic            w_tick, w_fall, w_wrap, w_left_next, w_data_slot;
  logic [PW-1:0]   w_p_next;
  logic [3:0]      w_idx;
  logic [15:0]     w_sh;

  always_comb begin
    w_tick      = (r_div == DivLast);
    w_fall      = w_tick && r_bclk;
    w_wrap      = (r_p == PLast);
    w_p_next    = w_wrap ? '0 : r_p + 1'b1;
    w_left_next = w_wrap ? ~r_left : r_left;
    w_idx       = 4'(w_p_next - 1'b1);
    w_sh        = w_left_next ? r_sh_l : r_sh_r;
    // Data periods are p=1..16; p=0 and the tail of the slot carry zeros.
    w_data_slot = (w_p_next != '0) && (w_p_next <= PW'(16));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_div       <= '0;
      r_bclk      <= 1'b0;
      r_lrck      <= 1'b0;
      r_p         <= PLast;
      r_left      <= 1'b0;
      r_got_left  <= 1'b0;
      r_adcdat    <= 1'b0;
      r_adc_load  <= 1'b0;
      r_dac_valid <= 1'b0;
      if (i_rst) begin
        r_dac_left  <= '0;
        r_dac_right <= '0;
        r_sh_l      <= '0;
        r_sh_r      <= '0;
        r_asm_l     <= '0;
        r_asm_r     <= '0;
      end
    end else begin
      r_adc_load  <= 1'b0;
      r_dac_valid <= 1'b0;
      if (w_tick) begin
        r_div  <= '0;
        r_bclk <= ~r_bclk;
      end else begin
        r_div <= r_div + 1'b1;
      end
      if (w_fall) begin
        if (r_p < PW'(16)) begin
          if (r_left) r_asm_l[r_p[3:0]] <= i_aud_dacdat;
          else        r_asm_r[r_p[3:0]] <= i_aud_dacdat;
        end
        r_p      <= w_p_next;
        r_left   <= w_left_next;
        r_lrck   <= w_left_next;
        r_adcdat <= w_data_slot ? w_sh[w_idx] : 1'b0;
        if (w_wrap) begin
          if (r_left) begin
            r_got_left <= 1'b1;
          end else begin
            // Entering a new frame: the right slot just closed the previous pair.
            r_sh_l     <= i_adc_left;
            r_sh_r     <= i_adc_right;
            r_adc_load <= 1'b1;
            r_got_left <= 1'b0;
            if (r_got_left) begin
              r_dac_left  <= r_asm_l;
              r_dac_right <= r_asm_r;
              r_dac_valid <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign o_adc_load    = r_adc_load;
  assign o_aud_bclk    = r_bclk;
  assign o_aud_adclrck = r_lrck;
  assign o_aud_daclrck = r_lrck;
  assign o_aud_adcdat  = r_adcdat;
  assign o_dac_left    = r_dac_left;
  assign o_dac_right   = r_dac_right;
  assign o_dac_valid   = r_dac_valid;

endmodule

// File: tb/tb_audio_codec_emu.sv
// Bench for audio_codec_emu: two configurations driven in lockstep and checked every cycle
// against a frame-arithmetic model, plus literal pins on timing and the data words.
module tb_audio_codec_emu;

  localparam int NI = 2;

  logic clk = 1'b0;
  logic rst, en;
  logic [15:0] adc_l, adc_r;
  logic [NI-1:0] dacdat, bclk, alr, dlr, adat, load, valid;
  logic [NI-1:0][15:0] dl, dr;

  always #5 clk = ~clk;

  audio_codec_emu #(.CLK_DIV(2), .SLOT_BITS(32)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_adc_left(adc_l), .i_adc_right(adc_r),
    .o_adc_load(load[0]), .o_aud_bclk(bclk[0]), .o_aud_adclrck(alr[0]),
    .o_aud_daclrck(dlr[0]), .o_aud_adcdat(adat[0]), .i_aud_dacdat(dacdat[0]),
    .o_dac_left(dl[0]), .o_dac_right(dr[0]), .o_dac_valid(valid[0])
  );

  audio_codec_emu #(.CLK_DIV(1), .SLOT_BITS(18)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_adc_left(adc_l), .i_adc_right(adc_r),
    .o_adc_load(load[1]), .o_aud_bclk(bclk[1]), .o_aud_adclrck(alr[1]),
    .o_aud_daclrck(dlr[1]), .o_aud_adcdat(adat[1]), .i_aud_dacdat(dacdat[1]),
    .o_dac_left(dl[1]), .o_dac_right(dr[1]), .o_dac_valid(valid[1])
  );

  function automatic int cd_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction
  function automatic int sb_of(input int i);
    return (i == 0) ? 32 : 18;
  endfunction

  int checks = 0, failures = 0, cyc = 0;
  bit force_tx;

  // Model state: n = enabled edges since the last start.
  int n[NI], m_p[NI], m_fr[NI];
  bit m_run[NI], m_left[NI];
  logic [15:0] lat_l[NI], lat_r[NI], cur_l[NI], cur_r[NI], exp_dl[NI], exp_dr[NI];
  logic e_bclk[NI], e_lr[NI], e_dat[NI], e_load[NI], e_valid[NI];

  // Observation state (from DUT pins, pinned against literals).
  logic prev_lr[NI], prev_bclk[NI];
  int lr_run[NI], lr_high[NI], prev_load_cyc[NI], load_gap[NI], since[NI], val_at[NI];
  bit seen[NI];
  logic [15:0] first_vl[NI], first_vr[NI], rx_w[NI], last_rx[NI];
  int rx_cnt[NI], last_cnt[NI];
  bit rx_nz[NI], last_nz[NI];

  task automatic chk1(input string nm, input int i, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d cyc=%0d got=%0b want=%0b", nm, i, cyc, act, exp);
    end
  endtask

  task automatic chkint(input string nm, input int i, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s inst%0d cyc=%0d got=%0h want=%0h", nm, i, cyc, act, exp);
    end
  endtask

  task automatic model_step(input int i);
    int cd, sb, h, f, g;
    bit fell;
    logic [15:0] w;
    cd = cd_of(i);
    sb = sb_of(i);
    e_load[i]  = 1'b0;
    e_valid[i] = 1'b0;
    if (rst) begin
      n[i] = 0;
      exp_dl[i] = '0;
      exp_dr[i] = '0;
    end else if (!en) begin
      n[i] = 0;
    end else begin
      n[i]++;
    end
    h = n[i] / cd;
    e_bclk[i] = logic'(h % 2);
    f = h / 2;
    if (f == 0) begin
      m_run[i] = 1'b0;
      e_lr[i]  = 1'b0;
      e_dat[i] = 1'b0;
    end else begin
      g = f - 1;
      m_run[i]  = 1'b1;
      m_left[i] = ((g / sb) % 2) == 0;
      m_p[i]    = g % sb;
      m_fr[i]   = g / (2 * sb);
      fell = (n[i] % cd == 0) && (h % 2 == 0);
      e_lr[i] = m_left[i];
      if (fell && m_left[i] && m_p[i] == 0) begin
        e_load[i] = 1'b1;
        lat_l[i] = adc_l;
        lat_r[i] = adc_r;
        if (m_fr[i] >= 1) begin
          e_valid[i] = 1'b1;
          exp_dl[i] = cur_l[i];
          exp_dr[i] = cur_r[i];
        end
        cur_l[i] = (m_fr[i] == 0 && force_tx) ? 16'h8001 : 16'($urandom);
        cur_r[i] = (m_fr[i] == 0 && force_tx) ? 16'h7FFE : 16'($urandom);
      end
      w = m_left[i] ? lat_l[i] : lat_r[i];
      e_dat[i] = (m_p[i] >= 1 && m_p[i] <= 16) ? w[m_p[i]-1] : 1'b0;
    end
  endtask

  task automatic monitor(input int i);
    if (rst || !en) begin
      since[i] = 0;
      seen[i] = 1'b0;
      prev_load_cyc[i] = -1;
    end
    if (load[i]) begin
      since[i]++;
      if (prev_load_cyc[i] >= 0) load_gap[i] = cyc - prev_load_cyc[i];
      prev_load_cyc[i] = cyc;
    end
    if (valid[i] && !seen[i]) begin
      seen[i] = 1'b1;
      val_at[i] = since[i];
      first_vl[i] = dl[i];
      first_vr[i] = dr[i];
    end
    if (alr[i] && !prev_lr[i]) begin
      lr_run[i] = 1;
      rx_cnt[i] = 0;
      rx_w[i] = '0;
      rx_nz[i] = 1'b0;
    end else if (alr[i]) begin
      lr_run[i]++;
    end
    // Reference receiver: sample ADCDAT on BCLK rising edges during the left slot.
    if (bclk[i] && !prev_bclk[i] && alr[i]) begin
      if (rx_cnt[i] >= 1 && rx_cnt[i] <= 16) rx_w[i][rx_cnt[i]-1] = adat[i];
      else if (adat[i]) rx_nz[i] = 1'b1;
      rx_cnt[i]++;
    end
    if (!alr[i] && prev_lr[i]) begin
      lr_high[i] = lr_run[i];
      last_rx[i] = rx_w[i];
      last_cnt[i] = rx_cnt[i];
      last_nz[i] = rx_nz[i];
    end
    prev_lr[i] = alr[i];
    prev_bclk[i] = bclk[i];
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NI; i++) begin
      model_step(i);
      chk1("bclk", i, bclk[i], e_bclk[i]);
      chk1("adclrck", i, alr[i], e_lr[i]);
      chk1("daclrck", i, dlr[i], e_lr[i]);
      chk1("adcdat", i, adat[i], e_dat[i]);
      chk1("adc_load", i, load[i], e_load[i]);
      chk1("dac_valid", i, valid[i], e_valid[i]);
      chkint("dac_left", i, int'(dl[i]), int'(exp_dl[i]));
      chkint("dac_right", i, int'(dr[i]), int'(exp_dr[i]));
      monitor(i);
      if (m_run[i] && m_p[i] < 16)
        dacdat[i] = m_left[i] ? cur_l[i][m_p[i]] : cur_r[i][m_p[i]];
      else
        dacdat[i] = 1'($urandom);
    end
  endtask

  task automatic pin_frame(input int i, input bit data);
    chkint("lrck_high_clks", i, lr_high[i], (i == 0) ? 128 : 36);
    chkint("adc_load_gap", i, load_gap[i], (i == 0) ? 256 : 72);
    chkint("first_valid_load_no", i, val_at[i], 2);
    if (data) begin
      chkint("rx_word", i, int'(last_rx[i]), 16'hA5C3);
      chkint("rx_bits_in_slot", i, last_cnt[i], (i == 0) ? 32 : 18);
      chkint("rx_zero_periods", i, int'(last_nz[i]), 0);
      chkint("first_dac_left", i, int'(first_vl[i]), 16'h8001);
      chkint("first_dac_right", i, int'(first_vr[i]), 16'h7FFE);
    end
  endtask

  initial begin
    int k, stop_left;
    for (int i = 0; i < NI; i++) begin
      n[i] = 0; m_run[i] = 0; m_p[i] = 0; m_fr[i] = 0; m_left[i] = 0;
      exp_dl[i] = '0; exp_dr[i] = '0; lat_l[i] = '0; lat_r[i] = '0;
      cur_l[i] = '0; cur_r[i] = '0; prev_lr[i] = 0; prev_bclk[i] = 0;
      lr_run[i] = 0; lr_high[i] = 0; prev_load_cyc[i] = -1; load_gap[i] = 0;
      since[i] = 0; val_at[i] = 0; seen[i] = 0; rx_cnt[i] = 0; last_cnt[i] = 0;
      rx_w[i] = '0; last_rx[i] = '0; rx_nz[i] = 0; last_nz[i] = 0;
      first_vl[i] = '0; first_vr[i] = '0;
    end
    dacdat = '0;
    rst = 1'b1;
    en = 1'b1;
    adc_l = 16'hA5C3;
    adc_r = 16'h0F01;
    force_tx = 1'b1;
    repeat (3) cycle();
    chkint("reset_dac_left", 0, int'(dl[0]), 0);
    chkint("reset_bclk", 1, int'(bclk[1]), 0);

    // Fixed samples and loopback words over the first frames.
    rst = 1'b0;
    repeat (600) cycle();
    for (int i = 0; i < NI; i++) pin_frame(i, 1'b1);

    // Abort mid left slot, then restart.
    k = 0;
    while (!(m_run[0] && m_left[0] && m_p[0] == 10 && m_fr[0] >= 2) && k < 2000) begin
      cycle();
      k++;
    end
    chkint("wait_left_p10", 0, int'(k < 2000), 1);
    en = 1'b0;
    repeat (6) cycle();
    chk1("stopped_bclk", 0, bclk[0], 1'b0);
    en = 1'b1;
    repeat (600) cycle();
    for (int i = 0; i < NI; i++) pin_frame(i, 1'b1);

    // Reset pulse mid right slot.
    force_tx = 1'b0;
    k = 0;
    while (!(m_run[0] && !m_left[0] && m_p[0] == 5) && k < 2000) begin
      cycle();
      k++;
    end
    chkint("wait_right_p5", 0, int'(k < 2000), 1);
    rst = 1'b1;
    cycle();
    chkint("rst_dac_left", 0, int'(dl[0]), 0);
    chkint("rst_dac_right", 0, int'(dr[0]), 0);
    rst = 1'b0;
    repeat (600) cycle();
    for (int i = 0; i < NI; i++) pin_frame(i, 1'b0);

    // Random samples every cycle, occasional stops and resets.
    stop_left = 0;
    for (int c = 0; c < 9000; c++) begin
      adc_l = 16'($urandom);
      adc_r = 16'($urandom);
      if (stop_left > 0) begin
        stop_left--;
        en = (stop_left == 0);
      end else if ($urandom_range(0, 1999) == 0) begin
        en = 1'b0;
        stop_left = $urandom_range(1, 20);
      end
      rst = ($urandom_range(0, 3999) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
